// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (IF) and load/store (LS) share one
// memory port with a single outstanding transaction and bounded IF starvation.
module mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int STRB_W   = XLEN / 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [XLEN-1:0]   o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [XLEN-1:0]   i_ls_addr,
  input  logic [XLEN-1:0]   i_ls_wdata,
  input  logic [STRB_W-1:0] i_ls_wstrb,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [XLEN-1:0]   o_ls_rdata,
  input  logic              i_flush,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [STRB_W-1:0] o_mem_wstrb,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] starve;
  logic       discard;

  logic in_idle;
  logic starve_max;
  logic ls_win;
  logic if_win;
  logic if_resp;

  // Handshake: a request is accepted only in the cycle where o_mem_req and
  // i_mem_gnt are both high; the matching o_x_gnt pulses in that same cycle.
  // Every output is gated by i_rst so nothing leaks while reset is held.
  assign in_idle    = i_rst && (state == IDLE);
  assign starve_max = (starve == 4'(MAX_WAIT));
  assign ls_win     = i_ls_req && !(i_if_req && starve_max);
  assign if_win     = i_if_req && !ls_win;

  assign o_mem_req = in_idle && (i_if_req || i_ls_req);
  assign o_ls_gnt  = o_mem_req && i_mem_gnt && ls_win;
  assign o_if_gnt  = o_mem_req && i_mem_gnt && if_win;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    o_mem_wstrb = '0;
    if (o_mem_req) begin
      if (ls_win) begin
        o_mem_addr  = i_ls_addr;
        o_mem_we    = i_ls_we;
        o_mem_wdata = i_ls_wdata;
        o_mem_wstrb = i_ls_wstrb;
      end else begin
        o_mem_addr  = i_if_addr;
      end
    end
  end

  // A flush arriving on the response cycle itself must also drop the fetch.
  assign if_resp     = i_rst && (state == BUSY_IF) && i_mem_rvalid;
  assign o_if_rvalid = if_resp && !discard && !i_flush;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_ls_rvalid = i_rst && (state == BUSY_LS) && i_mem_rvalid;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;

  assign dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      starve  <= '0;
      discard <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (o_mem_req && i_mem_gnt) begin
            if (ls_win) begin
              state <= BUSY_LS;
              if (i_if_req && !starve_max) starve <= starve + 4'd1;
            end else begin
              state  <= BUSY_IF;
              starve <= '0;
            end
          end
        end
        BUSY_IF: begin
          if (i_flush) discard <= 1'b1;
          if (i_mem_rvalid) begin
            state   <= IDLE;
            discard <= 1'b0;
          end
        end
        BUSY_LS: begin
          if (i_mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table followed by
// starvation, and reset-abandon sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .STRB_W(4), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata), .i_ls_wstrb(ls_wstrb), .o_ls_gnt(ls_gnt),
    .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
    .i_flush(flush),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        flush;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
  } vin_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        if_gnt;
    logic        ls_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic [1:0]  state;
  } vout_t;

  typedef struct {
    vin_t  vi;
    vout_t vo;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  function automatic vin_t mk_in(input logic [31:0] ifr, ifa, lsr, lwe, lsa,
                                 wd, ws, fl, g, rv, rd);
    vin_t r;
    r.if_req = ifr[0];  r.if_addr = ifa;   r.ls_req = lsr[0];
    r.ls_we = lwe[0];   r.ls_addr = lsa;   r.ls_wdata = wd;
    r.ls_wstrb = ws[3:0]; r.flush = fl[0]; r.mem_gnt = g[0];
    r.mem_rvalid = rv[0]; r.mem_rdata = rd;
    return r;
  endfunction

  function automatic vout_t mk_out(input logic [31:0] mr, we, ma, wd, ws, ig,
                                   lg, irv, ird, lrv, lrd, st);
    vout_t r;
    r.mem_req = mr[0];  r.mem_we = we[0];   r.mem_addr = ma;
    r.mem_wdata = wd;   r.mem_wstrb = ws[3:0]; r.if_gnt = ig[0];
    r.ls_gnt = lg[0];   r.if_rvalid = irv[0];  r.if_rdata = ird;
    r.ls_rvalid = lrv[0]; r.ls_rdata = lrd;  r.state = st[1:0];
    return r;
  endfunction

  function automatic vout_t sample();
    vout_t r;
    r = '{mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_gnt, ls_gnt,
          if_rvalid, if_rdata, ls_rvalid, ls_rdata, dbg_state};
    return r;
  endfunction

  task automatic add(input vin_t a, input vout_t b);
    vec_t v;
    v.vi = a;
    v.vo = b;
    vecs.push_back(v);
  endtask

  task automatic drive(input vin_t v);
    if_req = v.if_req;   if_addr = v.if_addr;   ls_req = v.ls_req;
    ls_we = v.ls_we;     ls_addr = v.ls_addr;   ls_wdata = v.ls_wdata;
    ls_wstrb = v.ls_wstrb; flush = v.flush;     mem_gnt = v.mem_gnt;
    mem_rvalid = v.mem_rvalid; mem_rdata = v.mem_rdata;
  endtask

  task automatic check_out(input string nm, input vout_t act, input vout_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vout_t zero_out;

  initial begin
    zero_out = '0;
    // Single IF fetch.
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 0, 'h100, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h13), mk_out(0, 0, 0, 0, 0, 0, 0, 1, 'h13, 0, 0, 1));
    // IF and LS store together: LS first, IF after the store ack.
    add(mk_in(1, 'h104, 1, 1, 'h200, 'hDEADBEEF, 'hF, 0, 1, 0, 0),
        mk_out(1, 1, 'h200, 'hDEADBEEF, 'hF, 0, 1, 0, 0, 0, 0, 0));
    add(mk_in(1, 'h104, 0, 0, 0, 0, 0, 0, 0, 1, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    add(mk_in(1, 'h104, 0, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 0, 'h104, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hAAAA0001),
        mk_out(0, 0, 0, 0, 0, 0, 0, 1, 'hAAAA0001, 0, 0, 1));
    // Memory stalls three cycles; winner changes from IF to LS meanwhile.
    add(mk_in(1, 'h108, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(1, 0, 'h108, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 1, 0, 'h300, 'h11, 'h3, 0, 0, 0, 0), mk_out(1, 0, 'h300, 'h11, 'h3, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 1, 0, 'h300, 'h11, 'h3, 0, 0, 0, 0), mk_out(1, 0, 'h300, 'h11, 'h3, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 1, 0, 'h300, 'h11, 'h3, 0, 1, 0, 0), mk_out(1, 0, 'h300, 'h11, 'h3, 0, 1, 0, 0, 0, 0, 0));
    // Busy: no request, no grant; flush during LS is harmless.
    add(mk_in(1, 'h108, 1, 0, 'h300, 'h11, 'h3, 1, 1, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h12345678), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h12345678, 2));
    // Flush while fetch outstanding, response two cycles later is dropped.
    add(mk_in(1, 'h10C, 0, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 0, 'h10C, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hBAD0BAD0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(mk_in(1, 'h110, 0, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 0, 'h110, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h600D), mk_out(0, 0, 0, 0, 0, 0, 0, 1, 'h600D, 0, 0, 1));
    // Flush on the response cycle itself.
    add(mk_in(1, 'h114, 0, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 0, 'h114, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'hFEED), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Stray rvalid in IDLE ignored; flush in IDLE has no effect.
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h77), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 'h118, 0, 0, 0, 0, 0, 1, 1, 0, 0), mk_out(1, 0, 'h118, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1234), mk_out(0, 0, 0, 0, 0, 0, 0, 1, 'h1234, 0, 0, 1));

    // Reset with requests pending: every output must stay low.
    rst = 1'b0;
    drive(mk_in(1, 'h100, 1, 1, 'h200, 'h5, 'hF, 0, 1, 1, 'h99));
    #12;
    check_out("reset_outputs", sample(), zero_out);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      next_cycle();
      drive(vecs[i].vi);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), sample(), vecs[i].vo);
    end

    // Starvation bound: with both held and memory always ready, IF gets
    // every fifth grant.
    exp_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    for (int g = 0; g < 11; g++) begin
      logic [1:0] exp;
      exp = exp_q.pop_front();
      next_cycle();
      drive(mk_in(1, 'h400, 1, 0, 'h500, 0, 0, 0, 1, 0, 0));
      @(negedge clk);
      check_bit($sformatf("starve_if_gnt%0d", g), if_gnt, exp[1]);
      check_bit($sformatf("starve_ls_gnt%0d", g), ls_gnt, exp[0]);
      next_cycle();
      drive(mk_in(1, 'h400, 1, 0, 'h500, 0, 0, 0, 1, 1, 'hC0DE));
      @(negedge clk);
      check_bit($sformatf("starve_if_rvalid%0d", g), if_rvalid, exp[1]);
      check_bit($sformatf("starve_ls_rvalid%0d", g), ls_rvalid, exp[0]);
    end

    // Reset in BUSY_LS abandons the store; stale rvalid afterwards ignored.
    next_cycle();
    drive(mk_in(0, 0, 1, 1, 'h600, 'h1, 'hF, 0, 1, 0, 0));
    @(negedge clk);
    check_bit("rst_seq_ls_gnt", ls_gnt, 1'b1);
    next_cycle();
    drive(mk_in(1, 'h700, 1, 1, 'h600, 'h1, 'hF, 1, 1, 1, 'hCAFE));
    rst = 1'b0;
    #1;
    check_out("reset_busy_immediate", sample(), zero_out);
    @(negedge clk);
    check_out("reset_busy_held", sample(), zero_out);
    next_cycle();
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCAFE));
    rst = 1'b1;
    @(negedge clk);
    check_out("post_reset_stale_rvalid", sample(), zero_out);
    next_cycle();
    @(negedge clk);
    check_out("post_reset_stale_rvalid2", sample(), zero_out);
    next_cycle();
    drive(mk_in(1, 'h800, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    check_out("post_reset_fetch", sample(), mk_out(1, 0, 'h800, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
